my_sync_fifo: RTL and testbench
===============================

// Module: my_sync_fifo
// PURPOSE
//  Portable single-clock FIFO; technology-independent successor to the FIFO18E1-based wrapper.
//  Adds free WIDTH/DEPTH, programmable almost-full/almost-empty thresholds and an exact occupancy count.
//  Buffers byte/word streams between UART/SD/keyboard front-ends and the minion core bus; infers LUT/BRAM storage.
// PARAMETERS
//  WIDTH      9    data word width in bits, >=1
//  DEPTH      512  entries; power of 2, >=4
//  AF_OFFSET  128  almostfull asserted when count >= DEPTH-AF_OFFSET; 1..DEPTH-1
//  AE_OFFSET  128  almostempty asserted when count <= AE_OFFSET; 0..DEPTH-1
// PORTS
//  clk          in   1                clock, all state on rising edge
//  rst          in   1                asynchronous reset, active-high
//  din          in   WIDTH            write data
//  wr_en        in   1                write request
//  rd_en        in   1                read request
//  dout         out  WIDTH            read data
//  full         out  1                count==DEPTH
//  empty        out  1                count==0
//  almostfull   out  1                see AF_OFFSET
//  almostempty  out  1                see AE_OFFSET
//  count        out  $clog2(DEPTH)+1  current occupancy 0..DEPTH
//  wrerr        out  1                1-cycle pulse: previous-cycle write rejected
//  rderr        out  1                1-cycle pulse: previous-cycle read rejected
// BEHAVIOUR
//  - One clock; reset asynchronous, active-high. Reset: wr_ptr=rd_ptr=0, count=0, empty=1, full=0,
//    almostempty=1, almostfull=0, wrerr=rderr=0, dout=0. Storage contents not cleared.
//  - Writes and reads ignored while rst high; reset mid-stream discards all queued data.
//  - Write accepted iff wr_en & ~full (registered full, pre-edge). Rejected write: no state change, wrerr=1 next cycle.
//  - Read accepted iff rd_en & ~empty (pre-edge). Rejected read: no state change, dout held, rderr=1 next cycle.
//  - Acceptance uses pre-edge flags only: full with wr_en&rd_en -> read accepted, write rejected (wrerr);
//    empty with wr_en&rd_en -> write accepted, read rejected (rderr).
//  - Pointers log2(DEPTH) bits, wrap DEPTH-1 -> 0 silently. count +1 write-only, -1 read-only, unchanged both/neither.
//  - All flags derived from registered count; update on the edge that changes count (write at edge N ->
//    empty=0 after edge N). No combinational path from wr_en/rd_en to any flag.
//  - Standard mode: dout registered; accepted read at edge N presents head word after edge N (1-cycle latency);
//    dout holds last value otherwise.
// CONFIGURATION
//  MY_SYNC_FIFO_FWFT_EN undefined: standard mode as above.
//  MY_SYNC_FIFO_FWFT_EN defined: first-word-fall-through; dout = storage[rd_ptr] whenever empty=0 (valid in the
//   cycle after the first write lands); rd_en acts as acknowledge, advances to next word same edge; dout don't-care
//   while empty. Flag, count and error rules unchanged.
// TESTING  (WIDTH=9, DEPTH=16, AF_OFFSET=4, AE_OFFSET=2)
//  Reset -> empty=1, almostempty=1, full=0, count=0, dout=0, wrerr=rderr=0.
//  Write 0x001..0x010 (16 words) -> count=16, full=1; almostfull from count 12; almostempty drops at count 3.
//  17th write while full -> wrerr pulses 1 cycle, count stays 16; 16 reads return 0x001..0x010 in order, empty=1.
//  Read while empty -> rderr pulse, dout holds 0x010; write+read same cycle while empty -> count=1, rderr=1.
//  Full, wr_en&rd_en together -> count=15, wrerr=1; 40 write/read pairs at count=8 -> count steady, data in order across wrap.
//  Assert rst mid-burst at count=9 -> all outputs at reset values immediately; next write then read returns new word.
//  FWFT build: single write 0x155 -> dout=0x155 with empty=0 next cycle, before any rd_en.

Source files
------------

// File: rtl/my_sync_fifo_if.sv
// Handshake/data bundle for my_sync_fifo.
// The master drives the write and read requests; the slave (the FIFO) drives data, flags and errors.
interface my_sync_fifo_if #(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned DEPTH = 512
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] din;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almostfull;
    logic             almostempty;
    logic [CW-1:0]    count;
    logic             wrerr;
    logic             rderr;

    modport master (
        output din, wr_en, rd_en,
        input  dout, full, empty, almostfull, almostempty, count, wrerr, rderr
    );

    modport slave (
        input  din, wr_en, rd_en,
        output dout, full, empty, almostfull, almostempty, count, wrerr, rderr
    );
endinterface

// File: rtl/my_sync_fifo.sv
// Single-clock FIFO with exact occupancy count, almost-full/almost-empty flags and error pulses.
// Define MY_SYNC_FIFO_FWFT_EN for first-word-fall-through; the default build uses a registered dout.
module my_sync_fifo #(
    parameter int unsigned WIDTH     = 9,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned AF_OFFSET = 128,
    parameter int unsigned AE_OFFSET = 128
) (
    input  logic          clk,
    input  logic          rst,
    my_sync_fifo_if.slave bus_io
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
    localparam logic [CW-1:0] AfCnt   = CW'(DEPTH - AF_OFFSET);
    localparam logic [CW-1:0] AeCnt   = CW'(AE_OFFSET);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wrerr_q, wrerr_d;
    logic             rderr_q, rderr_d;
    logic             full, empty, wr_ok, rd_ok;

    // Flags come only from the registered count, so no request input reaches them combinationally.
    assign full  = (count_q == FullCnt);
    assign empty = (count_q == '0);
    assign wr_ok = bus_io.wr_en & ~full;
    assign rd_ok = bus_io.rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wrerr_d  = bus_io.wr_en & ~wr_ok;
        rderr_d  = bus_io.rd_en & ~rd_ok;
        if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wrerr_q  <= 1'b0;
            rderr_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wrerr_q  <= wrerr_d;
            rderr_q  <= rderr_d;
        end
    end

    // Storage is deliberately left out of reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= bus_io.din;
    end

`ifdef MY_SYNC_FIFO_FWFT_EN
    assign bus_io.dout = empty ? '0 : mem_q[rd_ptr_q];
`else
    logic [WIDTH-1:0] dout_q, dout_d;

    always_comb begin
        dout_d = dout_q;
        if (rd_ok) dout_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) dout_q <= '0;
        else     dout_q <= dout_d;
    end

    assign bus_io.dout = dout_q;
`endif

    assign bus_io.full        = full;
    assign bus_io.empty       = empty;
    assign bus_io.almostfull  = (count_q >= AfCnt);
    assign bus_io.almostempty = (count_q <= AeCnt);
    assign bus_io.count       = count_q;
    assign bus_io.wrerr       = wrerr_q;
    assign bus_io.rderr       = rderr_q;
endmodule

// File: tb/tb_my_sync_fifo.sv
// Self-checking bench for my_sync_fifo (standard mode, WIDTH=9, DEPTH=16, AF_OFFSET=4, AE_OFFSET=2).
// A queue holds the words expected out; each accepted read pops the word dout must present next.
module tb_my_sync_fifo;
    localparam int unsigned WIDTH = 9;
    localparam int unsigned DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    my_sync_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    my_sync_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_OFFSET(4),
        .AE_OFFSET(2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus_io(bus)
    );

    int unsigned      chk_cnt = 0;
    int unsigned      err_cnt = 0;
    logic [WIDTH-1:0] sb_q[$];
    int               m_cnt = 0;
    logic [WIDTH-1:0] exp_dout = '0;
    logic             exp_wrerr = 1'b0;
    logic             exp_rderr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".count"}, 32'(bus.count), 32'(m_cnt));
        check_eq({tag, ".full"}, 32'(bus.full), 32'(m_cnt == DEPTH));
        check_eq({tag, ".empty"}, 32'(bus.empty), 32'(m_cnt == 0));
        check_eq({tag, ".afull"}, 32'(bus.almostfull), 32'(m_cnt >= 12));
        check_eq({tag, ".aempty"}, 32'(bus.almostempty), 32'(m_cnt <= 2));
        check_eq({tag, ".dout"}, 32'(bus.dout), 32'(exp_dout));
        check_eq({tag, ".wrerr"}, 32'(bus.wrerr), 32'(exp_wrerr));
        check_eq({tag, ".rderr"}, 32'(bus.rderr), 32'(exp_rderr));
    endtask

    // Drive one cycle of requests, predict its effect from pre-edge state, then check after the edge.
    task automatic cycle(input string tag, input logic w, input logic [WIDTH-1:0] d, input logic r);
        logic wok, rok;
        bus.wr_en = w;
        bus.din   = d;
        bus.rd_en = r;
        wok = w && (m_cnt != DEPTH);
        rok = r && (m_cnt != 0);
        if (rok) exp_dout = sb_q.pop_front();
        if (wok) sb_q.push_back(d);
        @(posedge clk);
        #1;
        if (wok && !rok) m_cnt++;
        if (rok && !wok) m_cnt--;
        exp_wrerr = w && !wok;
        exp_rderr = r && !rok;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        check_all(tag);
    endtask

    initial begin
        bus.din   = '0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        #2;
        check_all("reset_async");
        @(posedge clk);
        #1;
        check_all("reset_held");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 1; i <= 16; i++) cycle("fill", 1'b1, WIDTH'(i), 1'b0);
        cycle("wr_full", 1'b1, 9'h011, 1'b0);
        cycle("idle_after_wrerr", 1'b0, '0, 1'b0);
        for (int i = 0; i < 16; i++) cycle("drain", 1'b0, '0, 1'b1);
        cycle("rd_empty", 1'b0, '0, 1'b1);
        cycle("wr_rd_empty", 1'b1, 9'h0AA, 1'b1);
        cycle("rd_single", 1'b0, '0, 1'b1);

        for (int i = 0; i < 16; i++) cycle("refill", 1'b1, WIDTH'(9'h100 + i), 1'b0);
        cycle("wr_rd_full", 1'b1, 9'h1FF, 1'b1);
        while (m_cnt > 8) cycle("to_eight", 1'b0, '0, 1'b1);
        for (int i = 0; i < 40; i++) cycle("pairs", 1'b1, WIDTH'(9'h040 + i), 1'b1);

        cycle("to_nine", 1'b1, 9'h0F0, 1'b0);
        check_eq("pre_reset.count", 32'(bus.count), 32'd9);
        #3;
        rst = 1'b1;
        #1;
        sb_q.delete();
        m_cnt = 0;
        exp_dout = '0;
        exp_wrerr = 1'b0;
        exp_rderr = 1'b0;
        check_all("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        cycle("post_reset_wr", 1'b1, 9'h1C3, 1'b0);
        cycle("post_reset_rd", 1'b0, '0, 1'b1);
        check_eq("post_reset.word", 32'(bus.dout), 32'h1C3);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end
endmodule
